// File: rtl/rv32i_pkg.sv
// rv32i_pkg: constants and types shared by the RV32I decode stage.
//   Opcodes, cls_o bit positions (CLS_W wide), immediate format select,
//   skid occupancy encoding and the decoded-entry record held in the skid.
package rv32i_pkg;

  localparam int CLS_W = 12;

  localparam logic [6:0] OP_ARR   = 7'h33;
  localparam logic [6:0] OP_ARI   = 7'h13;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_SYS   = 7'h73;

  // cls_o = {csr, ebc, auipc, lui, jalr, jal, br, st, ld, ari, arr, mext}
  localparam int CLS_MEXT  = 0;
  localparam int CLS_ARR   = 1;
  localparam int CLS_ARI   = 2;
  localparam int CLS_LD    = 3;
  localparam int CLS_ST    = 4;
  localparam int CLS_BR    = 5;
  localparam int CLS_JAL   = 6;
  localparam int CLS_JALR  = 7;
  localparam int CLS_LUI   = 8;
  localparam int CLS_AUIPC = 9;
  localparam int CLS_EBC   = 10;
  localparam int CLS_CSR   = 11;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} occ_e;

  typedef struct packed {
    logic [31:0]      pc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic [CLS_W-1:0] cls;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/rv32i_idec_stage_if.sv
// rv32i_idec_stage_if: handshake bundle of the decode stage.
//   in side : in_valid_i, in_ready_o, instr_i, pc_i
//   out side: out_valid_o, out_ready_i, pc_o, rd_o, rs1_o, rs2_o,
//             funct3_o, funct7_o, imm_o, cls_o, illegal_o
//   Suffixes are from the stage's point of view; slave = the stage,
//   master = the fetch/issue environment around it.
interface rv32i_idec_stage_if;
  import rv32i_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic [31:0]      pc_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      pc_o;
  logic [4:0]       rd_o;
  logic [4:0]       rs1_o;
  logic [4:0]       rs2_o;
  logic [2:0]       funct3_o;
  logic [6:0]       funct7_o;
  logic [31:0]      imm_o;
  logic [CLS_W-1:0] cls_o;
  logic             illegal_o;

  modport master (
    output in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, imm_o, cls_o, illegal_o
  );

  modport slave (
    input  in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, imm_o, cls_o, illegal_o
  );

endinterface

// File: rtl/rv32i_imm.sv
// rv32i_imm: RV32I immediate generator (combinational).
//   instr_i : instruction bits [31:7] (the opcode bits never feed an immediate)
//   sel_i   : format select I/S/B/U/J
//   imm_o   : sign-extended 32-bit immediate
module rv32i_imm
  import rv32i_pkg::*;
(
  input  logic [31:7] instr_i,
  input  imm_sel_e    sel_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    case (sel_i)
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'h000};
      IMM_J: imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_idec_stage.sv
// rv32i_idec_stage: RV32I decode pipeline stage.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   flush_i : drop every held entry and the entry offered this cycle
//   bus     : rv32i_idec_stage_if.slave (in/out valid-ready handshakes)
// Decode is combinational on instr_i and captured on acceptance. With
// SKID=1 a two-slot skid sits behind a registered in_ready_o; with SKID=0
// only slot0 is used and in_ready_o follows the output handshake.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid_o low
// ST_ONE   | slot0 presented, slot1 free
// ST_TWO   | slot0 presented, slot1 holds the next entry, input stalled
module rv32i_idec_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned EN_M   = 1,
  parameter int unsigned EN_CSR = 1,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  rv32i_idec_stage_if.slave bus
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [CLS_W-1:0] cls_d;
  logic             illegal_d;
  imm_sel_e         imm_sel;
  logic [31:0]      imm_w;
  dec_t             dec_d;

  assign opcode = bus.instr_i[6:0];
  assign f3     = bus.instr_i[14:12];
  assign f7     = bus.instr_i[31:25];

  rv32i_imm u_imm (
    .instr_i (bus.instr_i[31:7]),
    .sel_i   (imm_sel),
    .imm_o   (imm_w)
  );

  // cls bits are only set on the legal path, so an illegal entry keeps cls=0.
  always_comb begin
    cls_d     = '0;
    illegal_d = 1'b0;
    imm_sel   = IMM_I;
    case (opcode)
      OP_ARR: begin
        if (f7 == 7'h00) begin
          cls_d[CLS_ARR] = 1'b1;
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          cls_d[CLS_ARR] = 1'b1;
        end else if (f7 == 7'h01 && EN_M != 0) begin
          cls_d[CLS_ARR]  = 1'b1;
          cls_d[CLS_MEXT] = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_ARI: begin
        if ((f3 == 3'd1 && f7 != 7'h00) ||
            (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) illegal_d = 1'b1;
        else cls_d[CLS_ARI] = 1'b1;
      end
      OP_LD: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) illegal_d = 1'b1;
        else cls_d[CLS_LD] = 1'b1;
      end
      OP_ST: begin
        imm_sel = IMM_S;
        if (f3 > 3'd2) illegal_d = 1'b1;
        else cls_d[CLS_ST] = 1'b1;
      end
      OP_BR: begin
        imm_sel = IMM_B;
        if (f3 == 3'd2 || f3 == 3'd3) illegal_d = 1'b1;
        else cls_d[CLS_BR] = 1'b1;
      end
      OP_JAL: begin
        imm_sel = IMM_J;
        cls_d[CLS_JAL] = 1'b1;
      end
      OP_JALR: begin
        if (f3 != 3'd0) illegal_d = 1'b1;
        else cls_d[CLS_JALR] = 1'b1;
      end
      OP_LUI: begin
        imm_sel = IMM_U;
        cls_d[CLS_LUI] = 1'b1;
      end
      OP_AUIPC: begin
        imm_sel = IMM_U;
        cls_d[CLS_AUIPC] = 1'b1;
      end
      OP_SYS: begin
        if (f3 == 3'd0) begin
          // only ecall (all zero) and ebreak (imm=1) are accepted
          if (bus.instr_i[31:7] == 25'h0 || bus.instr_i[31:7] == 25'h2000) cls_d[CLS_EBC] = 1'b1;
          else illegal_d = 1'b1;
        end else if (EN_CSR != 0) begin
          cls_d[CLS_CSR] = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_comb begin
    dec_d         = '0;
    dec_d.pc      = bus.pc_i;
    dec_d.rs1     = bus.instr_i[19:15];
    dec_d.funct3  = f3;
    dec_d.funct7  = f7;
    dec_d.imm     = imm_w;
    dec_d.cls     = cls_d;
    dec_d.illegal = illegal_d;
    if (!(illegal_d || cls_d[CLS_ST] || cls_d[CLS_BR] || cls_d[CLS_EBC])) dec_d.rd = bus.instr_i[11:7];
    if (cls_d[CLS_ARR] || cls_d[CLS_ST] || cls_d[CLS_BR]) dec_d.rs2 = bus.instr_i[24:20];
  end

  occ_e state_q, state_d;
  dec_t slot0_q, slot1_q;
  logic rdy_q, rdy_d;
  logic out_valid;
  logic push, pop;
  logic ld0_new, ld0_skid, ld1_new;

  assign out_valid      = (state_q != ST_EMPTY);
  assign bus.in_ready_o = (SKID != 0) ? rdy_q : (~out_valid | bus.out_ready_i);
  assign push           = bus.in_valid_i & bus.in_ready_o;
  assign pop            = out_valid & bus.out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld0_new  = 1'b0;
    ld0_skid = 1'b0;
    ld1_new  = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            ld0_new = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            ld0_new = 1'b1;
          end else if (push) begin
            state_d = ST_TWO;
            ld1_new = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready_o is low here, so only the pop side can move
          if (pop) begin
            state_d  = ST_ONE;
            ld0_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    rdy_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      if (ld0_new) slot0_q <= dec_d;
      else if (ld0_skid) slot0_q <= slot1_q;
      if (ld1_new) slot1_q <= dec_d;
    end
  end

  assign bus.out_valid_o = out_valid;
  assign bus.pc_o        = slot0_q.pc;
  assign bus.rd_o        = slot0_q.rd;
  assign bus.rs1_o       = slot0_q.rs1;
  assign bus.rs2_o       = slot0_q.rs2;
  assign bus.funct3_o    = slot0_q.funct3;
  assign bus.funct7_o    = slot0_q.funct7;
  assign bus.imm_o       = slot0_q.imm;
  assign bus.cls_o       = slot0_q.cls;
  assign bus.illegal_o   = slot0_q.illegal;

endmodule

// File: doc/rv32i_idec_stage.md
RV32I_IDEC_STAGE -- requirements
Module: rv32i_idec_stage

Interface
REQ-001 Parameter EN_M, default 1, decode RV32M (opcode 0x33, funct7 0x01) as legal arr with mext flag.
REQ-002 Parameter EN_CSR, default 1, decode SYSTEM funct3!=0 as csr class; if 0 these are illegal.
REQ-003 Parameter SKID, default 1; 1 = two-entry skid buffer, registered in_ready_o; 0 = single register, in_ready_o = !out_valid_o | out_ready_i.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 flush_i  in  1  discard all held entries.
REQ-007 in_valid_i  in  1  instr_i/pc_i valid.
REQ-008 in_ready_o  out  1  stage accepts this cycle.
REQ-009 instr_i  in  32  raw instruction.
REQ-010 pc_i  in  32  instruction address.
REQ-011 out_valid_o  out  1  decoded entry presented.
REQ-012 out_ready_i  in  1  consumer accepts.
REQ-013 pc_o  out  32  pc of presented entry.
REQ-014 rd_o, rs1_o, rs2_o  out  5 each  register indices.
REQ-015 funct3_o  out  3; funct7_o  out  7.
REQ-016 imm_o  out  32  sign-extended immediate.
REQ-017 cls_o  out  12  one-hot {csr, ebc, auipc, lui, jalr, jal, br, st, ld, ari, arr, mext}; all-zero when illegal.
REQ-018 illegal_o  out  1  entry is an illegal instruction.

Function
REQ-019 Decode is combinational on instr_i; results are registered at acceptance (in_valid_i & in_ready_o); output latency exactly 1 cycle when empty.
REQ-020 Opcode map: 0x33 arr, 0x13 ari, 0x03 ld, 0x23 st, 0x63 br, 0x6F jal, 0x67 jalr, 0x37 lui, 0x17 auipc, 0x73 ebc (funct3=0) / csr (funct3!=0).
REQ-021 Immediate select: jal J; lui/auipc U; br B; st S; all others I.
REQ-022 rd_o forced 0 for st, br, ebc and illegal; rs2_o forced 0 unless arr, st, br.
REQ-023 Illegal when: instr_i[1:0]!=2'b11; unknown opcode; ld funct3 in {3,6,7}; st funct3>2; br funct3 in {2,3}; jalr funct3!=0; arr funct7 not 0x00/0x20 (0x01 too when EN_M), or 0x20 with funct3 not 0/5; ari funct3=1 with funct7!=0, funct3=5 with funct7 not 0x00/0x20; ebc with instr_i[31:7] not 0 or 0x2000 (ecall/ebreak).
REQ-024 Illegal entries still flow through handshake with illegal_o=1, pc_o valid.
REQ-025 Transfer out occurs on out_valid_o & out_ready_i; entries leave in arrival order.
REQ-026 SKID=1: in_ready_o is a flop output, high when fewer than 2 entries held; accept with 1 held and simultaneous output pop keeps count 1, no bubble.
REQ-027 SKID=1 full (2 held): in_ready_o=0; in_valid_i ignored; no overwrite.
REQ-028 Outputs stable while out_valid_o & !out_ready_i.
REQ-029 flush_i has priority: next cycle count=0, out_valid_o=0; input presented in flush cycle is dropped.

Reset
REQ-030 rst_i asserted: immediately out_valid_o=0, in_ready_o=1, entry count=0, all data outputs 0, cls_o=0, illegal_o=0.
REQ-031 Reset mid-transfer discards all held entries; first acceptance allowed in first clock after release.

Structure
REQ-032 Package rv32i_pkg holds opcode constants, cls_o bit indices and width constant CLS_W=12.
REQ-033 Immediate generation reuses existing sub-module rv32i_imm; skid storage inline, no further sub-modules.

Verification
REQ-034 Reset then ADDI x1,x0,5 (0x00500093, pc 0x100), out_ready_i=1 -> next cycle out_valid_o=1, rd 1, imm 5, cls ari, pc_o 0x100.
REQ-035 Back-to-back 4 instrs, out_ready_i=0 two cycles -> in_ready_o drops after 2 accepted, order preserved, no loss/duplication on release.
REQ-036 BEQ offset -4 (0xFE000EE3) -> imm 0xFFFFFFFC, rd 0, cls br; SW 0x00112223 -> imm 4, rd 0, rs2 1.
REQ-037 0x02208033 (MUL) with EN_M=0 -> illegal_o=1, cls_o=0; EN_M=1 -> cls arr|mext.
REQ-038 Two entries held, flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, flushed input absent.
REQ-039 rst_i asserted asynchronously mid-stall -> out_valid_o falls without a clock edge.
